data_memory_master: RTL

//  Load/store initiator driving the word-wide, byte-enabled data memory.

---
 rtl/data_memory_master.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/data_memory_master.sv
// Load/store initiator for a word-wide, byte-enabled data memory; one request in flight.
// Define DATA_MEMORY_MASTER_SPLIT_EN to split word-crossing accesses into two beats.
module data_memory_master #(
  parameter int DATA_BITS = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [31:0]          req_addr,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_error,
  output logic [DATA_BITS-3:0] mem_address,
  output logic [3:0]           mem_byteena,
  output logic [31:0]          mem_data,
  output logic                 mem_wren,
  input  logic [31:0]          mem_q
);

  localparam int AW = DATA_BITS - 2;

`ifdef DATA_MEMORY_MASTER_SPLIT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC0 = 2'd1, S_ACC1 = 2'd2, S_RESP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC0 = 2'd1, S_RESP = 2'd3} state_t;
`endif

  // {hi,lo} >> 8*off, then sign/zero extension by access size
  function automatic logic [31:0] f_extract(input logic [31:0] hi, input logic [31:0] lo,
                                            input logic [1:0] off, input logic [1:0] size,
                                            input logic uns);
    logic [5:0]  sh;
    logic [31:0] raw;
    sh  = {1'b0, off, 3'b000};
    raw = (lo >> sh) | (hi << (6'd32 - sh));
    case (size)
      2'd0:    f_extract = {{24{raw[7] & ~uns}}, raw[7:0]};
      2'd1:    f_extract = {{16{raw[15] & ~uns}}, raw[15:0]};
      2'd2:    f_extract = raw;
      default: f_extract = 32'h0000_0000;
    endcase
  endfunction

  state_t          r_state, w_next;
  logic            r_ready, r_write, r_unsigned;
  logic [1:0]      r_size, r_off;
  logic            r_rsp_valid, r_rsp_error, r_mem_wren;
  logic [31:0]     r_rsp_rdata, r_mem_data;
  logic [3:0]      r_mem_byteena;
  logic [AW-1:0]   r_mem_address;

  logic [1:0]      w_off;
  logic [3:0]      w_mask;
  logic [7:0]      w_be8;
  logic [AW-1:0]   w_word;
  logic            w_cross, w_err;
`ifdef DATA_MEMORY_MASTER_SPLIT_EN
  logic            r_split;
  logic [3:0]      r_be_hi;
  logic [31:0]     r_data_hi, r_lo, w_data_hi;
`endif

  // request decode: lane mask, crossing detection and error classification
  always_comb begin
    w_off  = req_addr[1:0];
    w_word = req_addr[DATA_BITS-1:2];
    case (req_size)
      2'd0:    w_mask = 4'b0001;
      2'd1:    w_mask = 4'b0011;
      2'd2:    w_mask = 4'b1111;
      default: w_mask = 4'b0000;
    endcase
    w_be8   = {4'b0000, w_mask} << w_off;
    w_cross = |w_be8[7:4];
`ifdef DATA_MEMORY_MASTER_SPLIT_EN
    w_data_hi = req_wdata >> (6'd32 - {1'b0, w_off, 3'b000});
    w_err     = (req_size == 2'd3) | (|req_addr[31:DATA_BITS]) | (w_cross & (&w_word));
`else
    w_err     = (req_size == 2'd3) | (|req_addr[31:DATA_BITS]) | w_cross;
`endif
  end

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_next = w_err ? S_RESP : S_ACC0;
        else           w_next = S_IDLE;
      end
`ifdef DATA_MEMORY_MASTER_SPLIT_EN
      S_ACC0: begin
        if (r_split) w_next = S_ACC1;
        else         w_next = S_RESP;
      end
      S_ACC1:  w_next = S_RESP;
`else
      S_ACC0:  w_next = S_RESP;
`endif
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // datapath: mem/rsp outputs default to idle each cycle, the active state overrides
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ready       <= 1'b1;
      r_write       <= 1'b0;
      r_unsigned    <= 1'b0;
      r_size        <= 2'd0;
      r_off         <= 2'd0;
      r_rsp_valid   <= 1'b0;
      r_rsp_error   <= 1'b0;
      r_rsp_rdata   <= 32'h0000_0000;
      r_mem_wren    <= 1'b0;
      r_mem_data    <= 32'h0000_0000;
      r_mem_byteena <= 4'b0000;
      r_mem_address <= '0;
`ifdef DATA_MEMORY_MASTER_SPLIT_EN
      r_split       <= 1'b0;
      r_be_hi       <= 4'b0000;
      r_data_hi     <= 32'h0000_0000;
      r_lo          <= 32'h0000_0000;
`endif
    end else begin
      r_ready       <= (w_next == S_IDLE);
      r_rsp_valid   <= 1'b0;
      r_rsp_error   <= 1'b0;
      r_rsp_rdata   <= 32'h0000_0000;
      r_mem_wren    <= 1'b0;
      r_mem_data    <= 32'h0000_0000;
      r_mem_byteena <= 4'b0000;
      r_mem_address <= '0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_off      <= w_off;
            if (w_err) begin
              r_rsp_valid <= 1'b1;
              r_rsp_error <= 1'b1;
            end else begin
              r_mem_address <= w_word;
              r_mem_byteena <= w_be8[3:0];
              r_mem_data    <= req_wdata << {w_off, 3'b000};
              r_mem_wren    <= req_write;
`ifdef DATA_MEMORY_MASTER_SPLIT_EN
              r_split       <= w_cross;
              r_be_hi       <= w_be8[7:4];
              r_data_hi     <= w_data_hi;
`endif
            end
          end
        end
        S_ACC0: begin
`ifdef DATA_MEMORY_MASTER_SPLIT_EN
          if (r_split) begin
            r_lo          <= mem_q;
            r_mem_address <= r_mem_address + AW'(1);
            r_mem_byteena <= r_be_hi;
            r_mem_data    <= r_data_hi;
            r_mem_wren    <= r_write;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_write ? 32'h0000_0000
                                   : f_extract(32'h0000_0000, mem_q, r_off, r_size, r_unsigned);
          end
`else
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= r_write ? 32'h0000_0000
                                 : f_extract(32'h0000_0000, mem_q, r_off, r_size, r_unsigned);
`endif
        end
`ifdef DATA_MEMORY_MASTER_SPLIT_EN
        S_ACC1: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= r_write ? 32'h0000_0000
                                 : f_extract(mem_q, r_lo, r_off, r_size, r_unsigned);
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign req_ready   = r_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_error   = r_rsp_error;
  assign rsp_rdata   = r_rsp_rdata;
  assign mem_wren    = r_mem_wren;
  assign mem_data    = r_mem_data;
  assign mem_byteena = r_mem_byteena;
  assign mem_address = r_mem_address;

endmodule
